// File: rtl/palette_lut_banked_if.sv
// rtl/palette_lut_banked_if.sv - lookup, write and output bundle for the banked palette
// Purpose: groups every non-clock signal of palette_lut_banked.
// Ports (master = pixel source / loader, slave = palette):
//   pix_valid, pix_index, bank_sel, frame_tick, flash_en, bright   lookup side
//   wr_en, wr_bank, wr_index, wr_rgb                                 entry write side
//   out_valid, red, green, blue, flash_phase                         palette results
interface palette_lut_banked_if #(
    parameter int INDEX_W   = 5,
    parameter int CH_W      = 4,
    parameter int NUM_BANKS = 2
);
    localparam int BANK_W = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;

    logic                pix_valid;
    logic [INDEX_W-1:0]  pix_index;
    logic [BANK_W-1:0]   bank_sel;
    logic                frame_tick;
    logic                flash_en;
    logic [CH_W-1:0]     bright;
    logic                wr_en;
    logic [BANK_W-1:0]   wr_bank;
    logic [INDEX_W-1:0]  wr_index;
    logic [3*CH_W-1:0]   wr_rgb;
    logic                out_valid;
    logic [CH_W-1:0]     red;
    logic [CH_W-1:0]     green;
    logic [CH_W-1:0]     blue;
    logic                flash_phase;

    modport master (
        output pix_valid, pix_index, bank_sel, frame_tick, flash_en, bright,
        output wr_en, wr_bank, wr_index, wr_rgb,
        input  out_valid, red, green, blue, flash_phase
    );

    modport slave (
        input  pix_valid, pix_index, bank_sel, frame_tick, flash_en, bright,
        input  wr_en, wr_bank, wr_index, wr_rgb,
        output out_valid, red, green, blue, flash_phase
    );
endinterface

// File: rtl/palette_lut_banked.sv
// rtl/palette_lut_banked.sv - multi-bank runtime-writable colour palette with fade and flash
// Purpose: maps a palette index to 12-bit RGB through a 2-cycle pipeline. Stage 1 captures
//   the request and the effective bank (flash bank while flashing), stage 2 reads the entry,
//   applies the global brightness scale and registers the colour. Entries are written through
//   a single-cycle write port; a read of an entry on the edge it is written returns the old value.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    palette_lut_banked_if.slave (lookup, write, colour outputs, flash phase)
module palette_lut_banked #(
    parameter int INDEX_W      = 5,
    parameter int CH_W         = 4,
    parameter int NUM_BANKS    = 2,
    parameter int FLASH_BANK   = 1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    palette_lut_banked_if.slave   bus
);
    localparam int BANK_W   = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;
    localparam int NB2      = 2 ** BANK_W;
    localparam int ENTRIES  = 2 ** INDEX_W;
    localparam int RGB_W    = 3 * CH_W;
    localparam int CNT_W    = (FLASH_FRAMES > 2) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

    // One bit per addressable bank code: set only for banks that actually exist.
    function automatic logic [NB2-1:0] bank_mask_f();
        logic [NB2-1:0] m;
        for (int i = 0; i < NB2; i++) begin
            m[i] = (i < NUM_BANKS);
        end
        return m;
    endfunction
    localparam logic [NB2-1:0] BANK_MASK = bank_mask_f();

    // (c * (bright+1)) >> CH_W at 2*CH_W+1 bits; all-ones brightness passes c unchanged.
    function automatic logic [CH_W-1:0] scale_f(input logic [CH_W-1:0] c,
                                                 input logic [CH_W-1:0] b);
        logic [2*CH_W:0] p;
        p = (2*CH_W+1)'(c) * ((2*CH_W+1)'(b) + (2*CH_W+1)'(1));
        return p[2*CH_W-1:CH_W];
    endfunction

    typedef enum logic {PHASE0, PHASE1} phase_t;

    phase_t              state;
    phase_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                flash_phase;

    logic [RGB_W-1:0]    mem [NB2][ENTRIES];

    logic                s1_valid;
    logic [INDEX_W-1:0]  s1_index;
    logic [BANK_W-1:0]   s1_bank;
    logic [CH_W-1:0]     s1_bright;
    logic [BANK_W-1:0]   eff_bank;
    logic [RGB_W-1:0]    rd_rgb;

    logic                out_valid;
    logic [CH_W-1:0]     red;
    logic [CH_W-1:0]     green;
    logic [CH_W-1:0]     blue;

    // Flash phase FSM: counts frame ticks while enabled, toggles every FLASH_FRAMES ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PHASE0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!bus.flash_en) begin
            state_next = PHASE0;
            cnt_next   = '0;
        end else if (bus.frame_tick) begin
            if (cnt == CNT_LAST) begin
                cnt_next   = '0;
                state_next = (state == PHASE0) ? PHASE1 : PHASE0;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    assign flash_phase = (state == PHASE1);

    // The bank is frozen at capture so in-flight pixels are unaffected by flash changes.
    assign eff_bank = (bus.flash_en && flash_phase) ? BANK_W'(FLASH_BANK) : bus.bank_sel;

    // Palette storage. Writes to non-existent banks are dropped, so those rows stay zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB2; b++) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (bus.wr_en && BANK_MASK[bus.wr_bank]) begin
            mem[bus.wr_bank][bus.wr_index] <= bus.wr_rgb;
        end
    end

    // Stage 1: request capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_index  <= '0;
            s1_bank   <= '0;
            s1_bright <= '0;
        end else begin
            s1_valid  <= bus.pix_valid;
            s1_index  <= bus.pix_index;
            s1_bank   <= eff_bank;
            s1_bright <= bus.bright;
        end
    end

    // Read sees the pre-write contents because the write lands on the same edge.
    always_comb begin
        rd_rgb = '0;
        if (BANK_MASK[s1_bank]) begin
            rd_rgb = mem[s1_bank][s1_index];
        end
    end

    // Stage 2: scale and register; colour holds while no valid lookup arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                red   <= scale_f(rd_rgb[3*CH_W-1:2*CH_W], s1_bright);
                green <= scale_f(rd_rgb[2*CH_W-1:CH_W],   s1_bright);
                blue  <= scale_f(rd_rgb[CH_W-1:0],        s1_bright);
            end
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.red         = red;
    assign bus.green       = green;
    assign bus.blue        = blue;
    assign bus.flash_phase = flash_phase;
endmodule

// File: tb/tb_palette_lut_banked.sv
// tb/tb_palette_lut_banked.sv - self-checking bench for palette_lut_banked
module tb_palette_lut_banked;
    localparam int FF = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    palette_lut_banked_if #(.INDEX_W(5), .CH_W(4), .NUM_BANKS(2)) bus ();

    palette_lut_banked #(
        .INDEX_W(5), .CH_W(4), .NUM_BANKS(2), .FLASH_BANK(1), .FLASH_FRAMES(FF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int mem_m [2][32];
    int m_cnt, m_phase;
    int p_valid, p_bank, p_idx, p_bright;
    int exp_valid, exp_r, exp_g, exp_b;

    function automatic int scl(input int c, input int b);
        return (c * (b + 1)) / 16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 32; i++) mem_m[b][i] = 0;
        m_cnt = 0; m_phase = 0;
        p_valid = 0; p_bank = 0; p_idx = 0; p_bright = 0;
        exp_valid = 0; exp_r = 0; exp_g = 0; exp_b = 0;
    endtask

    // One clock: predict from current inputs, apply the edge, compare everything.
    task automatic tick();
        int rgb;
        exp_valid = p_valid;
        if (p_valid != 0) begin
            rgb   = (p_bank < 2) ? mem_m[p_bank][p_idx] : 0;
            exp_r = scl((rgb >> 8) & 15, p_bright);
            exp_g = scl((rgb >> 4) & 15, p_bright);
            exp_b = scl(rgb & 15, p_bright);
        end
        p_valid  = bus.pix_valid;
        p_bank   = (bus.flash_en && m_phase != 0) ? 1 : int'(bus.bank_sel);
        p_idx    = int'(bus.pix_index);
        p_bright = int'(bus.bright);
        if (bus.wr_en && bus.wr_bank < 2) mem_m[bus.wr_bank][bus.wr_index] = int'(bus.wr_rgb);
        if (!bus.flash_en) begin
            m_cnt = 0; m_phase = 0;
        end else if (bus.frame_tick) begin
            if (m_cnt == FF - 1) begin m_cnt = 0; m_phase = 1 - m_phase; end
            else m_cnt++;
        end
        @(posedge clk);
        #1;
        chk("valid", 32'(bus.out_valid), 32'(exp_valid));
        chk("red",   32'(bus.red),       32'(exp_r));
        chk("green", 32'(bus.green),     32'(exp_g));
        chk("blue",  32'(bus.blue),      32'(exp_b));
        chk("phase", 32'(bus.flash_phase), 32'(m_phase));
    endtask

    task automatic look(input bit v, input int idx, input int bank, input int br);
        bus.pix_valid = v;
        bus.pix_index = 5'(idx);
        bus.bank_sel  = 1'(bank);
        bus.bright    = 4'(br);
    endtask

    task automatic wr(input bit en, input int bank, input int idx, input int rgb);
        bus.wr_en    = en;
        bus.wr_bank  = 1'(bank);
        bus.wr_index = 5'(idx);
        bus.wr_rgb   = 12'(rgb);
    endtask

    task automatic frame_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            bus.frame_tick = 1'b1; tick();
            bus.frame_tick = 1'b0; tick();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'd0);
        chk({tag, "_phase"}, 32'(bus.flash_phase), 32'd0);
    endtask

    initial begin
        vectors = 0; errors = 0;
        rst_n = 1'b0;
        look(0, 0, 0, 15); wr(0, 0, 0, 0);
        bus.frame_tick = 1'b0; bus.flash_en = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: lookup after reset returns black
        look(1, 3, 0, 15); tick();
        look(0, 0, 0, 15); tick();
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h000);

        // 2: write then look up at full and half brightness
        wr(1, 0, 5, 12'hFE1); tick(); wr(0, 0, 0, 0);
        look(1, 5, 0, 15); tick();
        look(1, 5, 0, 7); tick();
        look(0, 0, 0, 15);
        chk("t2_full", 32'({bus.red, bus.green, bus.blue}), 32'hFE1);
        tick();
        chk("t2_half", 32'({bus.red, bus.green, bus.blue}), 32'h770);
        tick();
        chk("t2_hold", 32'({bus.red, bus.green, bus.blue}), 32'h770);

        // 3: read-during-write returns old value, next read the new one
        wr(1, 0, 9, 12'h123); tick();
        wr(0, 0, 0, 0); look(1, 9, 0, 15); tick();
        look(0, 0, 0, 15); wr(1, 0, 9, 12'hABC); tick();
        chk("t3_old", 32'({bus.red, bus.green, bus.blue}), 32'h123);
        wr(0, 0, 0, 0); look(1, 9, 0, 15); tick();
        look(0, 0, 0, 15); tick();
        chk("t3_new", 32'({bus.red, bus.green, bus.blue}), 32'hABC);

        // 4: flashing substitutes bank 1
        wr(1, 1, 5, 12'h3C7); tick(); wr(0, 0, 0, 0);
        bus.flash_en = 1'b1;
        frame_ticks(FF);
        chk("t4_phase1", 32'(bus.flash_phase), 32'd1);
        look(1, 5, 0, 15); tick();
        look(0, 0, 0, 15); tick();
        chk("t4_bank1", 32'({bus.red, bus.green, bus.blue}), 32'h3C7);
        frame_ticks(FF);
        chk("t4_phase0", 32'(bus.flash_phase), 32'd0);

        // 5: dropping enable mid-count clears to phase 0 on the next edge
        frame_ticks(FF + 5);
        chk("t5_pre", 32'(bus.flash_phase), 32'd1);
        bus.flash_en = 1'b0; look(1, 5, 0, 15); tick();
        chk("t5_cleared", 32'(bus.flash_phase), 32'd0);
        look(0, 0, 0, 15); tick();
        chk("t5_bank0", 32'({bus.red, bus.green, bus.blue}), 32'hFE1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            look($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1),
                 $urandom_range(0, 15));
            wr($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
               $urandom_range(0, 4095));
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            bus.flash_en   = ($urandom_range(0, 19) != 0);
            tick();
        end

        // 6: asynchronous reset with lookups in flight
        wr(0, 0, 0, 0); bus.frame_tick = 1'b0; bus.flash_en = 1'b0;
        wr(1, 0, 7, 12'h5A5); look(1, 7, 0, 15); tick();
        wr(0, 0, 0, 0); look(1, 7, 0, 15); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_async");
        model_reset();
        look(0, 0, 0, 15);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        look(1, 7, 0, 15); tick();
        look(1, 5, 0, 15); tick();
        look(0, 0, 0, 15);
        chk("t6_cleared7", 32'({bus.out_valid, bus.red, bus.green, bus.blue}), 32'h1000);
        tick();
        chk("t6_cleared5", 32'({bus.out_valid, bus.red, bus.green, bus.blue}), 32'h1000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
